// File: rtl/br_inject_arbiter_if.sv
// Bundle between local broadcast sources, the injection arbiter and the router local port.
// master = sources/router side (drives requests, payloads, ack_tx_i); slave = the arbiter.
interface br_inject_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [DATA_WIDTH-1:0] br_data_t;

    logic [N_REQ-1:0]     req_i;
    br_data_t [N_REQ-1:0] data_i;
    logic [N_REQ-1:0]     ack_o;
    logic [N_REQ-1:0]     err_o;
    logic                 tx_o;
    br_data_t             data_o;
    logic                 ack_tx_i;
    logic [IW-1:0]        grant_id_o;
    logic                 busy_o;

    modport master (
        output req_i, data_i, ack_tx_i,
        input  ack_o, err_o, tx_o, data_o, grant_id_o, busy_o
    );

    modport slave (
        input  req_i, data_i, ack_tx_i,
        output ack_o, err_o, tx_o, data_o, grant_id_o, busy_o
    );
endinterface

// File: rtl/br_inject_arbiter.sv
// Round-robin arbiter for the BrLite local injection port; req_i -> tx_o in 1 cycle.
// Backpressure: payload held on data_o with tx_o high until ack_tx_i or timeout, then an idle gap.
module br_inject_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    br_inject_arbiter_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef logic [DATA_WIDTH-1:0] br_data_t;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    br_data_t         data_q, data_d;
    logic             tx_q, tx_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [GW-1:0]    gap_q, gap_d;

    logic [N_REQ-1:0] elig;
    logic             found;
    logic [IW-1:0]    win;

    // A source is invisible in the cycle its completion pulse is out, so it cannot be re-granted at once.
    assign elig = bus.req_i & ~ack_q & ~err_q;

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        tx_d    = tx_q;
        ack_d   = '0;
        err_d   = '0;
        wait_d  = wait_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d  = bus.data_i[win];
                    grant_d = win;
                    ptr_d   = win;
                    tx_d    = 1'b1;
                    wait_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.ack_tx_i) begin
                    tx_d           = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    wait_d         = '0;
                    gap_d          = '0;
                    state_d        = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (TIMEOUT != 0 && wait_q == WW'(TIMEOUT - 1)) begin
                    tx_d           = 1'b0;
                    err_d[grant_q] = 1'b1;
                    wait_d         = '0;
                    gap_d          = '0;
                    state_d        = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (wait_q != '1) begin
                    // Saturates so a disabled timeout can sit in SEND forever without wrapping.
                    wait_d = wait_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            tx_q    <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.tx_o       = tx_q;
    assign bus.data_o     = data_q;
    assign bus.grant_id_o = grant_q;
    assign bus.ack_o      = ack_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_br_inject_arbiter.sv
// Bench for br_inject_arbiter: instance A (gap 2, timeout 8) and instance B (gap 0, no timeout).
module tb_br_inject_arbiter;
    logic clk_i;
    logic rst_ni;

    br_inject_arbiter_if #(.N_REQ(4), .DATA_WIDTH(64)) ifa ();
    br_inject_arbiter_if #(.N_REQ(4), .DATA_WIDTH(64)) ifb ();

    br_inject_arbiter #(.N_REQ(4), .DATA_WIDTH(64), .GAP_CYCLES(2), .TIMEOUT(8)) dut_a (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (ifa)
    );

    br_inject_arbiter #(.N_REQ(4), .DATA_WIDTH(64), .GAP_CYCLES(0), .TIMEOUT(0)) dut_b (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (ifb)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] dval [4];

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        logic       ack_tx;
        logic       exp_tx;
        logic [3:0] exp_ack;
        logic [1:0] exp_gid;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        ifa.req_i    = '0;
        ifa.ack_tx_i = 1'b0;
        ifb.req_i    = '0;
        ifb.ack_tx_i = 1'b0;
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    function automatic void add(input bit r, input logic [3:0] req, input logic ack_tx,
                                input logic tx, input logic [3:0] ea, input logic [1:0] g,
                                input logic busy);
        vec_t v;
        v.do_rst = r;  v.req = req;   v.ack_tx = ack_tx;
        v.exp_tx = tx; v.exp_ack = ea; v.exp_gid = g; v.exp_busy = busy;
        vecs.push_back(v);
    endfunction

    function automatic logic get_tx(input bit use_b);
        return use_b ? ifb.tx_o : ifa.tx_o;
    endfunction

    function automatic logic [1:0] get_gid(input bit use_b);
        return use_b ? ifb.grant_id_o : ifa.grant_id_o;
    endfunction

    task automatic set_in(input bit use_b, input logic [3:0] req, input logic ack_tx);
        if (use_b) begin
            ifb.req_i = req; ifb.ack_tx_i = ack_tx;
        end else begin
            ifa.req_i = req; ifa.ack_tx_i = ack_tx;
        end
    endtask

    // Accepts every transfer immediately; checks idle spacing and alternating grants.
    task automatic run_spacing(input bit use_b, input logic [3:0] req, input int exp_low,
                               input int ga, input int gb, input int ntr, input string tag);
        int low;
        int done;
        int exp_g;
        apply_reset();
        set_in(use_b, req, 1'b0);
        low  = 0;
        done = 0;
        for (int c = 0; c < 80 && done < ntr; c++) begin
            step();
            if (get_tx(use_b)) begin
                exp_g = (done % 2 == 0) ? ga : gb;
                if (done > 0) chk($sformatf("%s_low%0d", tag, done), 64'(low), 64'(exp_low));
                chk($sformatf("%s_gid%0d", tag, done), 64'(get_gid(use_b)), 64'(exp_g));
                done++;
                low = 0;
                set_in(use_b, req, 1'b1);
            end else begin
                low++;
                set_in(use_b, req, 1'b0);
            end
        end
        chk({tag, "_count"}, 64'(done), 64'(ntr));
        set_in(use_b, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) step();
    endtask

    initial begin
        int high;
        int errs;
        int acks;
        int ord2[2];

        dval[0] = 64'h0000_0000_0000_00AB;
        dval[1] = 64'h1111_0000_0000_0011;
        dval[2] = 64'hDEAD_BEEF_0000_0002;
        dval[3] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            ifa.data_i[i] = dval[i];
            ifb.data_i[i] = dval[i];
        end

        // Single source 0, router accepts in the 4th SEND cycle.
        add(1, 4'b0001, 0, 1, 4'b0000, 0, 1);
        add(0, 4'b0001, 0, 1, 4'b0000, 0, 1);
        add(0, 4'b0001, 0, 1, 4'b0000, 0, 1);
        add(0, 4'b0001, 0, 1, 4'b0000, 0, 1);
        add(0, 4'b0001, 1, 0, 4'b0001, 0, 1);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        // All four requesting after reset, immediate accept: grants 0,1,2,3.
        for (int g = 0; g < 4; g++) begin
            add(g == 0, 4'b1111, 0, 1, 4'b0000,           2'(g), 1);
            add(0,      4'b1111, 1, 0, 4'(4'b0001 << g),  2'(g), 1);
            add(0,      4'b1111, 0, 0, 4'b0000,           2'(g), 1);
            add(0,      4'b1111, 0, 0, 4'b0000,           2'(g), 0);
        end
        // Then only 0 and 2 requesting: grants 0,2.
        ord2[0] = 0;
        ord2[1] = 2;
        for (int j = 0; j < 2; j++) begin
            add(0, 4'b0101, 0, 1, 4'b0000,                 2'(ord2[j]), 1);
            add(0, 4'b0101, 1, 0, 4'(4'b0001 << ord2[j]),  2'(ord2[j]), 1);
            add(0, 4'b0101, 0, 0, 4'b0000,                 2'(ord2[j]), 1);
            add(0, 4'b0101, 0, 0, 4'b0000,                 2'(ord2[j]), 0);
        end

        ifa.req_i = '0; ifa.ack_tx_i = 1'b0;
        ifb.req_i = '0; ifb.ack_tx_i = 1'b0;
        rst_ni = 1'b0;
        step();
        chk("rst_a_tx",   64'(ifa.tx_o), 0);
        chk("rst_a_busy", 64'(ifa.busy_o), 0);
        chk("rst_a_ack",  64'(ifa.ack_o), 0);
        chk("rst_a_err",  64'(ifa.err_o), 0);
        chk("rst_a_data", ifa.data_o, 0);
        chk("rst_a_gid",  64'(ifa.grant_id_o), 0);
        chk("rst_b_tx",   64'(ifb.tx_o), 0);
        chk("rst_b_busy", 64'(ifb.busy_o), 0);
        step();
        rst_ni = 1'b1;
        step();
        chk("idle_a_tx", 64'(ifa.tx_o), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) apply_reset();
            ifa.req_i    = vecs[i].req;
            ifa.ack_tx_i = vecs[i].ack_tx;
            step();
            chk($sformatf("vec%0d_tx", i),   64'(ifa.tx_o),       64'(vecs[i].exp_tx));
            chk($sformatf("vec%0d_ack", i),  64'(ifa.ack_o),      64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_err", i),  64'(ifa.err_o),      0);
            chk($sformatf("vec%0d_gid", i),  64'(ifa.grant_id_o), 64'(vecs[i].exp_gid));
            chk($sformatf("vec%0d_busy", i), 64'(ifa.busy_o),     64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_data", i), ifa.data_o,          dval[vecs[i].exp_gid]);
        end

        // Timeout: source 2 never accepted.
        apply_reset();
        ifa.req_i = 4'b0100;
        high = 0; errs = 0; acks = 0;
        step();
        chk("to_lat", 64'(ifa.tx_o), 1);
        if (ifa.tx_o) high++;
        for (int c = 0; c < 30; c++) begin
            step();
            if (ifa.tx_o) high++;
            if (ifa.ack_o != 0) acks++;
            if (ifa.err_o != 0) begin
                chk("to_err_vec", 64'(ifa.err_o), 64'(4'b0100));
                errs++;
                ifa.req_i = 4'b0000;
            end
        end
        chk("to_high", 64'(high), 8);
        chk("to_errs", 64'(errs), 1);
        chk("to_acks", 64'(acks), 0);

        // Accept in the last cycle before timeout: ack wins.
        apply_reset();
        ifa.req_i = 4'b0010;
        high = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ifa.tx_o) high++;
        end
        chk("late_high", 64'(high), 8);
        ifa.ack_tx_i = 1'b1;
        step();
        ifa.ack_tx_i = 1'b0;
        ifa.req_i    = 4'b0000;
        chk("late_ack", 64'(ifa.ack_o), 64'(4'b0010));
        chk("late_err", 64'(ifa.err_o), 0);
        chk("late_tx",  64'(ifa.tx_o), 0);
        step();
        chk("late_ack_pulse", 64'(ifa.ack_o), 0);
        chk("late_err_after", 64'(ifa.err_o), 0);

        run_spacing(1'b0, 4'b0011, 3, 0, 1, 5, "gap2");
        run_spacing(1'b1, 4'b1001, 1, 0, 3, 5, "gap0");
        run_spacing(1'b1, 4'b0001, 2, 0, 0, 4, "gap0_single");

        // Timeout disabled: stays in SEND indefinitely.
        apply_reset();
        ifb.req_i = 4'b0010;
        errs = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ifb.err_o != 0) errs++;
        end
        chk("noto_tx",   64'(ifb.tx_o), 1);
        chk("noto_errs", 64'(errs), 0);
        ifb.ack_tx_i = 1'b1;
        step();
        ifb.ack_tx_i = 1'b0;
        ifb.req_i    = 4'b0000;
        chk("noto_ack", 64'(ifb.ack_o), 64'(4'b0010));

        // Reset in the middle of a transfer for source 2.
        apply_reset();
        ifa.req_i = 4'b0100;
        step();
        step();
        chk("mid_pre_tx",  64'(ifa.tx_o), 1);
        chk("mid_pre_gid", 64'(ifa.grant_id_o), 2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_tx",   64'(ifa.tx_o), 0);
        chk("mid_rst_ack",  64'(ifa.ack_o), 0);
        chk("mid_rst_err",  64'(ifa.err_o), 0);
        chk("mid_rst_busy", 64'(ifa.busy_o), 0);
        chk("mid_rst_gid",  64'(ifa.grant_id_o), 0);
        chk("mid_rst_data", ifa.data_o, 0);
        step();
        ifa.req_i = 4'b0101;
        rst_ni = 1'b1;
        step();
        chk("mid_post_tx",   64'(ifa.tx_o), 1);
        chk("mid_post_gid",  64'(ifa.grant_id_o), 0);
        chk("mid_post_data", ifa.data_o, dval[0]);
        chk("mid_post_ack",  64'(ifa.ack_o), 0);
        chk("mid_post_err",  64'(ifa.err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
